// File: rtl/sr_trace_buffer.sv
// Retirement-trace recorder: captures {pc, instr, a0} into a FIFO during an armed,
// cycle-budgeted window and replays the entries through a valid/ready port.
module sr_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_LIMIT = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        stop,
  input  logic        cap_en,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] a0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_data,
  output logic        busy,
  output logic        timeout,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [15:0] cycle_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 96;
  localparam logic [15:0] LIMIT = 16'(CYCLE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     cycle_q, cycle_d;
  logic            timeout_q, timeout_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_q, drop_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            full_c, empty_c, push_c, pop_c, drop_c;

  // Next-state, FIFO bookkeeping and sticky status.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push_c     = 1'b0;
    drop_c     = 1'b0;

    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    pop_c   = !empty_c && out_ready;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = CAPTURE;
          cycle_d    = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          drop_d     = '0;
        end
      end
      CAPTURE: begin
        cycle_d = cycle_q + 16'd1;
        if (cap_en) begin
          if (!full_c || pop_c) push_c = 1'b1;
          else                  drop_c = 1'b1;
        end
        if (drop_c) begin
          overflow_d = 1'b1;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        // Budget exhaustion wins the timeout flag even when stop coincides.
        if (cycle_d == LIMIT) begin
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end else if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (empty_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_c && !rst) mem_q[wr_ptr_q] <= {pc, instr, a0};
  end

  assign out_valid = !empty_c;
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;
  assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Scoreboard bench for sr_trace_buffer (DEPTH=4, CYCLE_LIMIT=8): stimulus queues
// expected entries, an independent monitor pops and compares on each handshake.
module tb_sr_trace_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst, arm, stop, cap_en, out_ready;
  logic [31:0] pc, instr, a0;
  logic        out_valid, busy, timeout, overflow;
  logic [95:0] out_data;
  logic [7:0]  drop_cnt;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int base;
  logic [95:0] exp_q[$];

  sr_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .cap_en(cap_en),
    .pc(pc), .instr(instr), .a0(a0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout(timeout), .overflow(overflow),
    .drop_cnt(drop_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk(input int t, input int i);
    logic [31:0] p, n, r;
    p = 32'(t * 32'h1000 + i * 4);
    n = 32'hA500_0000 + 32'(t * 16 + i);
    r = ~p;
    return {p, n, r};
  endfunction

  task automatic set_sample(input int t, input int i);
    logic [95:0] s;
    s = mk(t, i);
    pc    = s[95:64];
    instr = s[63:32];
    a0    = s[31:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy; i++) step();
    check(name, 32'(busy), 32'd0);
  endtask

  // Monitor: sampled mid-cycle, so the handshake seen here is the one taken at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no entry", out_data);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
          end
        end
        pops++;
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    pc = '0; instr = '0; a0 = '0;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_cycle", 32'(cycle_cnt), 32'd0);
    rst = 1'b0;

    // Basic capture to timeout while streaming out.
    base = pops;
    out_ready = 1'b1; arm = 1'b1; step(); arm = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cap_en = 1'b1; set_sample(1, i); exp_q.push_back(mk(1, i)); step();
    end
    cap_en = 1'b0;
    check("t1_timeout", 32'(timeout), 32'd1);
    check("t1_cycle", 32'(cycle_cnt), 32'd8);
    check("t1_busy_drain", 32'(busy), 32'd1);
    wait_idle("t1_idle");
    check("t1_pops", 32'(pops - base), 32'd8);
    check("t1_timeout_hold", 32'(timeout), 32'd1);

    // Overflow: only the first DEPTH samples survive.
    base = pops;
    out_ready = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    check("t2_timeout_clr", 32'(timeout), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cap_en = 1'b1; set_sample(2, i);
      if (i < 4) exp_q.push_back(mk(2, i));
      step();
    end
    cap_en = 1'b0;
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_drop", 32'(drop_cnt), 32'd4);
    check("t2_timeout", 32'(timeout), 32'd1);
    out_ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_pops", 32'(pops - base), 32'd4);

    // Push and pop at full, then stop coinciding with the budget edge.
    base = pops;
    out_ready = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap_en = 1'b1; set_sample(3, i); exp_q.push_back(mk(3, i)); step();
    end
    check("t3_count_full", 32'(u_dut.count_q), 32'd4);
    out_ready = 1'b1;
    for (int i = 4; i < 7; i++) begin
      cap_en = 1'b1; set_sample(3, i); exp_q.push_back(mk(3, i)); step();
    end
    check("t3_count_hold", 32'(u_dut.count_q), 32'd4);
    cap_en = 1'b0; out_ready = 1'b0; stop = 1'b1; step(); stop = 1'b0;
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_cycle", 32'(cycle_cnt), 32'd8);
    check("t3_drop", 32'(drop_cnt), 32'd0);
    check("t3_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_pops", 32'(pops - base), 32'd7);

    // Early stop; arm and samples during DRAIN are ignored.
    base = pops;
    out_ready = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap_en = 1'b1; stop = (i == 2); set_sample(4, i); exp_q.push_back(mk(4, i)); step();
    end
    cap_en = 1'b0; stop = 1'b0;
    check("t4_cycle", 32'(cycle_cnt), 32'd3);
    check("t4_timeout", 32'(timeout), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    arm = 1'b1; cap_en = 1'b1; set_sample(4, 9); step(); arm = 1'b0; cap_en = 1'b0;
    check("t4_arm_ignored", 32'(cycle_cnt), 32'd3);
    check("t4_busy_drain", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_idle("t4_idle");
    check("t4_pops", 32'(pops - base), 32'd3);
    check("t4_cycle_hold", 32'(cycle_cnt), 32'd3);

    // Reset mid-capture flushes the FIFO.
    out_ready = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap_en = 1'b1; set_sample(5, i); step();
    end
    cap_en = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cycle", 32'(cycle_cnt), 32'd0);
    check("t5_drop", 32'(drop_cnt), 32'd0);
    base = pops;
    out_ready = 1'b1; arm = 1'b1; step(); arm = 1'b0;
    for (int i = 10; i < 12; i++) begin
      cap_en = 1'b1; stop = (i == 11); set_sample(5, i); exp_q.push_back(mk(5, i)); step();
    end
    cap_en = 1'b0; stop = 1'b0;
    check("t5_cycle_new", 32'(cycle_cnt), 32'd2);
    wait_idle("t5_idle");
    check("t5_pops", 32'(pops - base), 32'd2);

    // Intermittent sampling over the full budget.
    base = pops;
    out_ready = 1'b1; arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_en = (i % 2 == 0); set_sample(6, i);
      if (i % 2 == 0) exp_q.push_back(mk(6, i));
      step();
    end
    cap_en = 1'b0;
    check("t6_cycle", 32'(cycle_cnt), 32'd8);
    check("t6_timeout", 32'(timeout), 32'd1);
    wait_idle("t6_idle");
    check("t6_pops", 32'(pops - base), 32'd4);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
